// File: rtl/operand_mux_stage.sv
// ---------------------------------------------------------------------------
// operand_mux_stage
// Selects one of NUM_IN operands from a flat bus and passes it through a
// 2-entry skid buffer with valid/ready handshakes on both sides.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   flush      synchronous pipeline clear (lower priority than reset)
//   in_bus     NUM_IN*WIDTH flat operands, input k at [k*WIDTH +: WIDTH]
//   in_sel     operand select for the offered beat
//   in_valid   upstream beat offered
//   in_ready   stage can accept a beat this cycle (registered)
//   out_data   selected operand (zero for an out-of-range select)
//   out_sel    select value that produced out_data
//   out_err    beat carried an out-of-range select
//   out_valid  out_data/out_sel/out_err valid
//   out_ready  downstream accepts the beat
// ---------------------------------------------------------------------------
module operand_mux_stage #(
   parameter  int unsigned WIDTH  = 32,
   parameter  int unsigned NUM_IN = 4,
   localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [NUM_IN*WIDTH-1:0]   in_bus,
   input  logic [SEL_W-1:0]          in_sel,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_sel,
   output logic                      out_err,
   output logic                      out_valid,
   input  logic                      out_ready
);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SEL_W-1:0] sel;
      logic             err;
   } beat_t;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   logic [1:0]       state_q, state_d;
   beat_t            head_q, head_d;   // beat presented on the outputs
   beat_t            skid_q, skid_d;   // second beat, only used in ST_TWO
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   logic [WIDTH-1:0] sel_data;
   logic             sel_hit;
   beat_t            new_beat;
   logic             acc;
   logic             dlv;

   // Operand mux; a select with no matching input leaves data at zero.
   always_comb begin
      sel_data = '0;
      sel_hit  = 1'b0;
      for (int k = 0; k < int'(NUM_IN); k++) begin
         if (in_sel == SEL_W'(k)) begin
            sel_data = in_bus[k*WIDTH +: WIDTH];
            sel_hit  = 1'b1;
         end
      end
   end

   // With NUM_IN a power of two every select matches, so err folds to 0.
   assign new_beat.data = sel_data;
   assign new_beat.sel  = in_sel;
   assign new_beat.err  = ~sel_hit;

   assign acc = in_valid & in_ready_q;
   assign dlv = out_valid_q & out_ready;

   // Next-state and datapath update for the skid buffer.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;

      case (state_q)
         ST_EMPTY: begin
            if (acc) begin
               head_d  = new_beat;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (acc && dlv) begin
               head_d = new_beat;
            end else if (acc) begin
               skid_d  = new_beat;
               state_d = ST_TWO;
            end else if (dlv) begin
               head_d  = '0;
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (dlv) begin
               head_d  = skid_q;
               skid_d  = '0;
               state_d = ST_ONE;
            end
         end
         default: begin
            head_d  = '0;
            skid_d  = '0;
            state_d = ST_EMPTY;
         end
      endcase

      // Flush discards held beats and any same-cycle acceptance.
      if (flush) begin
         head_d  = '0;
         skid_d  = '0;
         state_d = ST_EMPTY;
      end

      in_ready_d  = (state_d != ST_TWO);
      out_valid_d = (state_d != ST_EMPTY);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         head_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = head_q.data;
   assign out_sel   = head_q.sel;
   assign out_err   = head_q.err;

endmodule

// File: tb/tb_operand_mux_stage.sv
// ---------------------------------------------------------------------------
// tb_operand_mux_stage
// Drives a NUM_IN=4 and a NUM_IN=3 instance with shared handshake stimulus.
// A reference model (a queue of in-flight beats per instance) is updated on
// each rising edge; a monitor compares the presented outputs on falling edges.
// ---------------------------------------------------------------------------
module tb_operand_mux_stage;

   typedef struct {
      logic [31:0] d;
      logic [1:0]  s;
      logic        e;
   } beat_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         flush;
   logic [127:0] in_bus;
   logic [1:0]   in_sel;
   logic         in_valid;
   logic         out_ready;

   logic         in_ready4, out_err4, out_valid4;
   logic [31:0]  out_data4;
   logic [1:0]   out_sel4;
   logic         in_ready3, out_err3, out_valid3;
   logic [31:0]  out_data3;
   logic [1:0]   out_sel3;

   int n_checks = 0;
   int n_fail   = 0;
   int n_dlv    = 0;
   int dut_dlv  = 0;
   bit started  = 1'b0;

   beat_t sb4[$];
   beat_t sb3[$];

   always #5 clk = ~clk;

   operand_mux_stage #(.WIDTH(32), .NUM_IN(4)) dut4 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_bus(in_bus), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready4),
      .out_data(out_data4), .out_sel(out_sel4), .out_err(out_err4),
      .out_valid(out_valid4), .out_ready(out_ready)
   );

   operand_mux_stage #(.WIDTH(32), .NUM_IN(3)) dut3 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_bus(in_bus[95:0]), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready3),
      .out_data(out_data3), .out_sel(out_sel3), .out_err(out_err3),
      .out_valid(out_valid3), .out_ready(out_ready)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic beat_t ref_beat(input logic [127:0] bus, input logic [1:0] sel, input int n_in);
      beat_t b;
      b.s = sel;
      if (int'(sel) < n_in) begin
         b.d = 32'(bus >> (32 * int'(sel)));
         b.e = 1'b0;
      end else begin
         b.d = 32'h0;
         b.e = 1'b1;
      end
      return b;
   endfunction

   // Reference model: at most two beats in flight, FIFO order.
   always @(posedge clk) begin
      if (reset) begin
         sb4.delete();
         sb3.delete();
         started <= 1'b1;
      end else if (started) begin
         if (flush) begin
            sb4.delete();
            sb3.delete();
         end else begin
            bit dlv, acc;
            dlv = (sb4.size() > 0) && out_ready;
            acc = in_valid && (sb4.size() < 2);
            if (dlv) begin
               void'(sb4.pop_front());
               void'(sb3.pop_front());
               n_dlv++;
            end
            if (acc) begin
               sb4.push_back(ref_beat(in_bus, in_sel, 4));
               sb3.push_back(ref_beat(in_bus, in_sel, 3));
            end
         end
      end
   end

   // Monitor: compare whatever the DUTs present against the model head.
   always @(negedge clk) begin
      if (started) begin
         chk("in_ready4", 64'(in_ready4), 64'(sb4.size() < 2));
         chk("in_ready3", 64'(in_ready3), 64'(sb3.size() < 2));
         chk("out_valid4", 64'(out_valid4), 64'(sb4.size() > 0));
         chk("out_valid3", 64'(out_valid3), 64'(sb3.size() > 0));
         if (sb4.size() > 0) begin
            chk("out_data4", 64'(out_data4), 64'(sb4[0].d));
            chk("out_sel4",  64'(out_sel4),  64'(sb4[0].s));
            chk("out_err4",  64'(out_err4),  64'(sb4[0].e));
            chk("out_data3", 64'(out_data3), 64'(sb3[0].d));
            chk("out_sel3",  64'(out_sel3),  64'(sb3[0].s));
            chk("out_err3",  64'(out_err3),  64'(sb3[0].e));
         end else begin
            chk("idle_out4", 64'({out_data4, out_sel4, out_err4}), 64'h0);
            chk("idle_out3", 64'({out_data3, out_sel3, out_err3}), 64'h0);
         end
         if (out_valid4 === 1'b1 && out_ready && !reset && !flush) dut_dlv++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_sel    = 2'd0;
      in_bus    = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

      // Reset state; in_valid held high must not be accepted during reset.
      step();
      step();
      chk("rst_in_ready", 64'(in_ready4), 64'h1);
      chk("rst_out_valid", 64'(out_valid4), 64'h0);
      chk("rst_outputs", 64'({out_data4, out_sel4, out_err4}), 64'h0);
      reset = 1'b0;

      // Select sweep, one beat per cycle.
      for (int i = 0; i < 4; i++) begin
         in_sel = 2'(i);
         step();
         chk("sweep_data", 64'(out_data4), 64'(32'h11111111 * (i + 1)));
         chk("sweep_sel", 64'(out_sel4), 64'(i));
         chk("sweep_err", 64'(out_err4), 64'h0);
         chk("sweep_valid", 64'(out_valid4), 64'h1);
      end
      in_valid = 1'b0;
      step();
      chk("sweep_drain", 64'(out_valid4), 64'h0);

      // Out-of-range select on the NUM_IN=3 instance.
      in_valid = 1'b1;
      in_sel   = 2'd3;
      step();
      chk("oor_data3", 64'(out_data3), 64'h0);
      chk("oor_sel3", 64'(out_sel3), 64'h3);
      chk("oor_err3", 64'(out_err3), 64'h1);
      chk("oor_data4", 64'(out_data4), 64'h44444444);
      in_sel = 2'd1;
      step();
      chk("inr_err3", 64'(out_err3), 64'h0);
      chk("inr_data3", 64'(out_data3), 64'h22222222);
      in_valid = 1'b0;
      step();

      // Backpressure: A, B fill the stage, C stalls until space frees.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_sel    = 2'd0;
      step();
      chk("bp_a_ready", 64'(in_ready4), 64'h1);
      in_sel = 2'd1;
      step();
      chk("bp_full", 64'(in_ready4), 64'h0);
      in_sel = 2'd2;
      step();
      chk("bp_stall_ready", 64'(in_ready4), 64'h0);
      chk("bp_hold_a", 64'(out_data4), 64'h11111111);
      out_ready = 1'b1;
      step();
      chk("bp_b", 64'(out_data4), 64'h22222222);
      step();
      chk("bp_c", 64'(out_data4), 64'h33333333);
      chk("bp_c_valid", 64'(out_valid4), 64'h1);
      in_valid = 1'b0;
      step();
      chk("bp_drain", 64'(out_valid4), 64'h0);

      // Flush while full, with a beat offered on the same edge.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_sel    = 2'd0;
      step();
      in_sel = 2'd1;
      step();
      flush  = 1'b1;
      in_sel = 2'd2;
      step();
      chk("flush_valid", 64'(out_valid4), 64'h0);
      chk("flush_ready", 64'(in_ready4), 64'h1);
      chk("flush_data", 64'(out_data4), 64'h0);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("flush_after", 64'(out_valid4), 64'h0);

      // Reset while full and draining.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_sel    = 2'd0;
      step();
      in_sel = 2'd1;
      step();
      reset     = 1'b1;
      out_ready = 1'b1;
      in_sel    = 2'd2;
      step();
      chk("mrst_valid", 64'(out_valid4), 64'h0);
      chk("mrst_outputs", 64'({out_data4, out_sel4, out_err4}), 64'h0);
      chk("mrst_ready", 64'(in_ready4), 64'h1);
      reset  = 1'b0;
      in_sel = 2'd3;
      step();
      chk("mrst_first", 64'(out_data4), 64'h44444444);
      chk("mrst_first_sel", 64'(out_sel4), 64'h3);
      in_valid = 1'b0;
      step();

      // Randomized traffic with occasional flush and reset.
      for (int c = 0; c < 10000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_sel    = 2'($urandom_range(0, 3));
         in_bus    = {$urandom, $urandom, $urandom, $urandom};
         flush     = ($urandom_range(0, 199) == 0);
         reset     = ($urandom_range(0, 499) == 0);
         step();
      end
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();
      chk("delivered_count", 64'(dut_dlv), 64'(n_dlv));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/operand_mux_stage.md
OPERAND_MUX_STAGE -- requirements
Module: operand_mux_stage

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, width of each data operand in bits (legal range 1..64).
REQ-002 SHALL provide parameter NUM_IN, default 4, number of selectable operand inputs (legal range 2..16).
REQ-003 SHALL derive localparam SEL_W = ceil(log2(NUM_IN)); it is not user-overridable.
REQ-004 SHALL use one clock; reset is synchronous and active-high. Ports are clk (input, 1, rising-edge clock) and reset (input, 1, synchronous active-high reset).
REQ-005 flush  input  1  synchronous pipeline clear, lower priority than reset.
REQ-006 in_bus  input  NUM_IN*WIDTH  flat operand inputs; input k occupies bits [k*WIDTH +: WIDTH].
REQ-007 in_sel  input  SEL_W  operand select for the offered beat.
REQ-008 in_valid  input  1  upstream beat offered.
REQ-009 in_ready  output  1  stage can accept a beat this cycle.
REQ-010 out_data  output  WIDTH  selected operand.
REQ-011 out_sel  output  SEL_W  select value that produced out_data (tag).
REQ-012 out_err  output  1  beat carried an out-of-range select.
REQ-013 out_valid  output  1  out_data/out_sel/out_err valid.
REQ-014 out_ready  input  1  downstream accepts the beat.

Function
REQ-015 A beat SHALL be accepted on a rising edge when in_valid=1 and in_ready=1; it is delivered on a rising edge when out_valid=1 and out_ready=1.
REQ-016 At acceptance the stage SHALL capture in_bus[in_sel*WIDTH +: WIDTH], in_sel, and err = (in_sel >= NUM_IN).
REQ-017 When err=1, the captured data SHALL be all zeros; the beat is still delivered, with out_err=1.
REQ-018 The stage SHALL be a 2-entry skid buffer with states EMPTY, ONE and TWO; in_ready SHALL be a registered output, 1 in EMPTY and ONE and 0 in TWO.
REQ-019 State transitions (acc = accept, dlv = deliver):
  - EMPTY: acc -> ONE; otherwise stay EMPTY.
  - ONE: acc and not dlv -> TWO; dlv and not acc -> EMPTY; acc and dlv, or neither -> stay ONE.
  - TWO: dlv -> ONE; otherwise stay TWO. No acceptance is possible in TWO.
REQ-020 out_valid SHALL be 1 exactly in states ONE and TWO.
REQ-021 Output fields SHALL be driven from registers only, with no combinational path from in_bus/in_sel to out_*.
REQ-022 Latency SHALL be 1 cycle: a beat accepted at edge N is visible on the outputs after edge N when the stage was EMPTY, or when it was ONE with a same-cycle delivery.
REQ-023 Beats SHALL be delivered strictly in acceptance order, with no loss and no duplication.
REQ-024 Sustained throughput SHALL be 1 beat per cycle while out_ready=1.
REQ-025 Output fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 When out_valid=0, out_data, out_sel and out_err SHALL be 0.
REQ-027 in_bus and in_sel SHALL be ignored while in_valid=0 or in_ready=0.
REQ-028 flush=1 SHALL force state EMPTY at the next edge, discarding all held beats and any same-cycle acceptance; no beat is delivered on that edge, and in_ready=1 afterwards.
REQ-029 When NUM_IN is a power of two, out_err SHALL be constant 0.

Reset
REQ-030 reset=1 at a rising edge SHALL force state EMPTY, out_valid=0, in_ready=1, and out_data=0, out_sel=0, out_err=0, overriding flush, in_valid and out_ready.
REQ-031 Reset asserted mid-transfer SHALL discard all held beats; no beat SHALL appear on the outputs until a new acceptance after reset deasserts.
REQ-032 During reset in_ready SHALL read 1, but no acceptance SHALL occur.

Verification
REQ-033 Select sweep (defaults): in_bus inputs 0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444; in_sel = 0..3 on consecutive cycles, out_ready=1 -> out_data 0x11111111..0x44444444 one cycle later each, out_sel matching, out_err=0.
REQ-034 Backpressure: out_ready=0, offer beats A, B, C -> A and B accepted, in_ready=0 after B, C stalls; raise out_ready -> A, B, C delivered in order, with no gap once flowing.
REQ-035 Out of range (NUM_IN=3): in_sel=3 -> out_data=0, out_sel=3, out_err=1; next beat with in_sel=1 -> out_err=0.
REQ-036 Flush: state TWO holding A and B, flush=1 together with in_valid=1 (beat C) -> next cycle out_valid=0, in_ready=1, and A, B and C are never delivered.
REQ-037 Reset mid-stream: reset=1 while in TWO with out_ready=1 -> next cycle out_valid=0, all outputs 0, in_ready=1; first post-reset beat appears after 1 cycle.
REQ-038 Random: random in_valid/out_ready/in_sel for 10k cycles against a scoreboard FIFO model -> zero mismatches, no beat lost or duplicated.
